// File: rtl/linea_retardo_habilitada_pkg.sv
// Shared definitions for the enabled tapped delay line: default widths,
// default reset value and the (stage, channel) -> bit-offset mapping of the
// flattened tap bus.
package linea_retardo_habilitada_pkg;

    localparam int BITS_DATO_DEF      = 8;
    localparam int VALOR_EN_RESET_DEF = 0;

    // Bit offset of stage 'etapa', channel 'canal' inside the flattened tap bus.
    function automatic int desplazamiento_derivacion(input int etapa,
                                                     input int canal,
                                                     input int canales,
                                                     input int bits_dato);
        return (etapa * canales + canal) * bits_dato;
    endfunction

endpackage

// File: rtl/linea_retardo_habilitada_etapa.sv
// One delay stage: CANALES samples of BITS_DATO bits plus a valid bit.
// Loads on enable, clears synchronously on reset (active-low) or limpiar.
module etapa_retardo
    import linea_retardo_habilitada_pkg::*;
#(
    parameter int BITS_DATO      = BITS_DATO_DEF,
    parameter int CANALES        = 1,
    parameter int VALOR_EN_RESET = VALOR_EN_RESET_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         habilitador,
    input  logic                         limpiar,
    input  logic [CANALES*BITS_DATO-1:0] datos_i,
    input  logic                         valido_i,
    output logic [CANALES*BITS_DATO-1:0] datos_o,
    output logic                         valido_o
);

    localparam logic [BITS_DATO-1:0] VALOR_CANAL = BITS_DATO'(VALOR_EN_RESET);

    logic [CANALES*BITS_DATO-1:0] datos_q;
    logic                         valido_q;

    // Stage register: reset/clear beats enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset || limpiar) begin
            datos_q  <= {CANALES{VALOR_CANAL}};
            valido_q <= 1'b0;
        end else if (habilitador) begin
            datos_q  <= datos_i;
            valido_q <= valido_i;
        end
    end

    assign datos_o  = datos_q;
    assign valido_o = valido_q;

endmodule

// File: rtl/linea_retardo_habilitada.sv
// Multi-channel tapped delay line with enable, synchronous clear, circular
// (recirculate) mode and a registered occupancy count of valid stages.
module linea_retardo_habilitada
    import linea_retardo_habilitada_pkg::*;
#(
    parameter int BITS_DATO      = BITS_DATO_DEF,
    parameter int ETAPAS         = 4,
    parameter int CANALES        = 1,
    parameter int VALOR_EN_RESET = VALOR_EN_RESET_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                habilitador,
    input  logic                                limpiar,
    input  logic                                circular,
    input  logic                                valido_entrada,
    input  logic [CANALES*BITS_DATO-1:0]        datos_entrada,
    output logic [ETAPAS*CANALES*BITS_DATO-1:0] derivaciones,
    output logic [CANALES*BITS_DATO-1:0]        datos_salida,
    output logic                                valido_salida,
    output logic [$clog2(ETAPAS+1)-1:0]         conteo,
    output logic                                llena
);

    localparam int W  = CANALES * BITS_DATO;
    localparam int CW = $clog2(ETAPAS + 1);

    logic [W-1:0]      datos_etapa [ETAPAS];
    logic [ETAPAS-1:0] valido_etapa;

    logic [W-1:0]  entrada0_d;
    logic          valido0_d;
    logic [CW-1:0] conteo_d, conteo_q;
    logic          llena_d, llena_q;

    // Stage-0 source: the input in linear mode, the last stage in circular mode.
    always_comb begin
        entrada0_d = datos_entrada;
        valido0_d  = valido_entrada;
        if (circular) begin
            entrada0_d = datos_etapa[ETAPAS-1];
            valido0_d  = valido_etapa[ETAPAS-1];
        end
    end

    for (genvar s = 0; s < ETAPAS; s++) begin : g_etapa
        localparam int OFS = desplazamiento_derivacion(s, 0, CANALES, BITS_DATO);
        if (s == 0) begin : g_primera
            etapa_retardo #(
                .BITS_DATO      (BITS_DATO),
                .CANALES        (CANALES),
                .VALOR_EN_RESET (VALOR_EN_RESET)
            ) u_etapa (
                .clk         (clk),
                .reset       (reset),
                .habilitador (habilitador),
                .limpiar     (limpiar),
                .datos_i     (entrada0_d),
                .valido_i    (valido0_d),
                .datos_o     (datos_etapa[s]),
                .valido_o    (valido_etapa[s])
            );
        end else begin : g_resto
            etapa_retardo #(
                .BITS_DATO      (BITS_DATO),
                .CANALES        (CANALES),
                .VALOR_EN_RESET (VALOR_EN_RESET)
            ) u_etapa (
                .clk         (clk),
                .reset       (reset),
                .habilitador (habilitador),
                .limpiar     (limpiar),
                .datos_i     (datos_etapa[s-1]),
                .valido_i    (valido_etapa[s-1]),
                .datos_o     (datos_etapa[s]),
                .valido_o    (valido_etapa[s])
            );
        end
        assign derivaciones[OFS +: W] = datos_etapa[s];
    end

    // Occupancy next state: linear shift adds the incoming valid and drops the
    // outgoing one; recirculation and hold leave the population unchanged.
    // Modular arithmetic keeps the result exact even if the +1 wraps first.
    always_comb begin
        conteo_d = conteo_q;
        if (habilitador && !circular) begin
            conteo_d = conteo_q + CW'(valido_entrada) - CW'(valido_etapa[ETAPAS-1]);
        end
        llena_d = (conteo_d == CW'(ETAPAS));
    end

    // Occupancy and full-flag registers, cleared with the stages.
    always_ff @(posedge clk) begin
        if (!reset || limpiar) begin
            conteo_q <= '0;
            llena_q  <= 1'b0;
        end else begin
            conteo_q <= conteo_d;
            llena_q  <= llena_d;
        end
    end

    assign datos_salida  = datos_etapa[ETAPAS-1];
    assign valido_salida = valido_etapa[ETAPAS-1];
    assign conteo        = conteo_q;
    assign llena         = llena_q;

endmodule

// File: tb/tb_linea_retardo_habilitada.sv
// Self-checking bench for linea_retardo_habilitada (BITS_DATO=8, ETAPAS=4,
// CANALES=2): a reference model pushes expected outputs into a queue at drive
// time; they are popped and compared after each clock edge.
module tb_linea_retardo_habilitada;

    localparam int BITS_DATO = 8;
    localparam int ETAPAS    = 4;
    localparam int CANALES   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        habilitador;
    logic        limpiar;
    logic        circular;
    logic        valido_entrada;
    logic [15:0] datos_entrada;
    logic [63:0] derivaciones;
    logic [15:0] datos_salida;
    logic        valido_salida;
    logic [2:0]  conteo;
    logic        llena;

    typedef struct packed {
        logic [63:0] der;
        logic [15:0] sal;
        logic        vout;
        logic [2:0]  cnt;
        logic        lle;
    } esperado_t;

    esperado_t cola [$];

    logic [7:0] m_dat [ETAPAS][CANALES];
    logic       m_v   [ETAPAS];

    int n_ok    = 0;
    int n_total = 0;

    linea_retardo_habilitada #(
        .BITS_DATO      (BITS_DATO),
        .ETAPAS         (ETAPAS),
        .CANALES        (CANALES),
        .VALOR_EN_RESET (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .habilitador    (habilitador),
        .limpiar        (limpiar),
        .circular       (circular),
        .valido_entrada (valido_entrada),
        .datos_entrada  (datos_entrada),
        .derivaciones   (derivaciones),
        .datos_salida   (datos_salida),
        .valido_salida  (valido_salida),
        .conteo         (conteo),
        .llena          (llena)
    );

    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: obtenido=%h esperado=%h", tag, obs, esp);
    endtask

    function automatic esperado_t modelo_salidas();
        esperado_t e;
        int pop;
        pop = 0;
        for (int s = 0; s < ETAPAS; s++) begin
            for (int c = 0; c < CANALES; c++)
                e.der[(s*CANALES+c)*8 +: 8] = m_dat[s][c];
            if (m_v[s]) pop++;
        end
        e.sal  = {m_dat[ETAPAS-1][1], m_dat[ETAPAS-1][0]};
        e.vout = m_v[ETAPAS-1];
        e.cnt  = 3'(pop);
        e.lle  = (pop == ETAPAS);
        return e;
    endfunction

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic paso(input logic rst_n, input logic hab, input logic clr,
                        input logic circ, input logic vin, input logic [7:0] d0,
                        input logic [7:0] d1);
        esperado_t e;
        logic [7:0] ult0, ult1;
        logic       ultv;
        @(negedge clk);
        reset          = rst_n;
        habilitador    = hab;
        limpiar        = clr;
        circular       = circ;
        valido_entrada = vin;
        datos_entrada  = {d1, d0};
        if (!rst_n || clr) begin
            for (int s = 0; s < ETAPAS; s++) begin
                m_v[s] = 1'b0;
                for (int c = 0; c < CANALES; c++) m_dat[s][c] = 8'd0;
            end
        end else if (hab) begin
            ult0 = m_dat[ETAPAS-1][0];
            ult1 = m_dat[ETAPAS-1][1];
            ultv = m_v[ETAPAS-1];
            for (int s = ETAPAS-1; s > 0; s--) begin
                m_v[s] = m_v[s-1];
                for (int c = 0; c < CANALES; c++) m_dat[s][c] = m_dat[s-1][c];
            end
            if (circ) begin
                m_dat[0][0] = ult0; m_dat[0][1] = ult1; m_v[0] = ultv;
            end else begin
                m_dat[0][0] = d0; m_dat[0][1] = d1; m_v[0] = vin;
            end
        end
        cola.push_back(modelo_salidas());
        @(posedge clk);
        #1;
        if (cola.size() == 0) begin
            chequear("cola_vacia", 64'd0, 64'd1);
        end else begin
            e = cola.pop_front();
            chequear("sb_derivaciones", derivaciones, e.der);
            chequear("sb_datos_salida", 64'(datos_salida), 64'(e.sal));
            chequear("sb_valido_salida", 64'(valido_salida), 64'(e.vout));
            chequear("sb_conteo", 64'(conteo), 64'(e.cnt));
            chequear("sb_llena", 64'(llena), 64'(e.lle));
        end
    endtask

    initial begin
        logic [2:0] conteo_esp [8];
        logic       vout_esp   [8];
        logic       vin_pat    [8];
        conteo_esp = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
        vout_esp   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vin_pat    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int s = 0; s < ETAPAS; s++) begin
            m_v[s] = 1'b0;
            for (int c = 0; c < CANALES; c++) m_dat[s][c] = 8'd0;
        end
        reset = 1'b0; habilitador = 1'b0; limpiar = 1'b0; circular = 1'b0;
        valido_entrada = 1'b0; datos_entrada = '0;

        // Reset held two cycles with enable high.
        paso(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 8'hBB);
        paso(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 8'hBB);
        chequear("rst_derivaciones", derivaciones, 64'd0);
        chequear("rst_valido_salida", 64'(valido_salida), 64'd0);
        chequear("rst_conteo", 64'(conteo), 64'd0);
        chequear("rst_llena", 64'(llena), 64'd0);

        // Fill with 11,22,33,44 (ch1 = ch0 + 1).
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd11, 8'd12);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd22, 8'd23);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd33, 8'd34);
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd44, 8'd45);
        chequear("fill_derivaciones", derivaciones, 64'h0C0B_1716_2221_2D2C);
        chequear("fill_conteo", 64'(conteo), 64'd4);
        chequear("fill_llena", 64'(llena), 64'd1);
        chequear("fill_datos_salida", 64'(datos_salida), 64'h0C0B);

        // Circular: four enabled edges bring the line back; 99 never enters.
        for (int i = 0; i < 4; i++) paso(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd99, 8'd99);
        chequear("circ_derivaciones", derivaciones, 64'h0C0B_1716_2221_2D2C);
        chequear("circ_conteo", 64'(conteo), 64'd4);

        // Steady full: valid in and valid out on the same edge.
        paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd55, 8'd56);
        chequear("full_conteo", 64'(conteo), 64'd4);
        chequear("full_datos_salida", 64'(datos_salida), 64'h1716);
        for (int i = 0; i < 3; i++) paso(1'b1, 1'b0, 1'b0, 1'(i), 1'b1, 8'hEE, 8'hEF);
        chequear("hold_derivaciones", derivaciones, 64'h1716_2221_2D2C_3837);
        chequear("hold_conteo", 64'(conteo), 64'd4);

        // Bubbles and drain from an empty line.
        paso(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd2);
        for (int i = 0; i < 8; i++) begin
            paso(1'b1, 1'b1, 1'b0, 1'b0, vin_pat[i], 8'(8'd100 + i), 8'(8'd200 + i));
            chequear($sformatf("burb_conteo_%0d", i), 64'(conteo), 64'(conteo_esp[i]));
            chequear($sformatf("burb_vout_%0d", i), 64'(valido_salida), 64'(vout_esp[i]));
        end

        // Clear beats enable on a full line, then reset beats enable.
        for (int i = 0; i < 4; i++) paso(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'(8'd60 + i), 8'(8'd70 + i));
        chequear("pre_clr_llena", 64'(llena), 64'd1);
        paso(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd77, 8'd78);
        chequear("clr_derivaciones", derivaciones, 64'd0);
        chequear("clr_conteo", 64'(conteo), 64'd0);
        paso(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd88, 8'd89);
        chequear("rst2_derivaciones", derivaciones, 64'd0);
        chequear("rst2_conteo", 64'(conteo), 64'd0);

        // Random traffic, checked by the scoreboard only.
        for (int i = 0; i < 200; i++) begin
            paso(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
